// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the unified-memory arbiter (IF fetch port vs MEM data port).
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_t;

    // Width of a counter that must hold values 0..lat.
    function automatic int lat_cnt_w(input int lat);
        return $clog2(lat + 1);
    endfunction

endpackage

// File: rtl/mem_arbiter_timer.sv
// Loadable saturating down-counter; done_o is high while the count sits at zero.
module arb_lat_timer #(
    parameter int           W       = 2,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         done_o
);

    logic [W-1:0] count;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count <= RST_VAL;
        end else if (load_i) begin
            count <= load_val_i;
        end else if (dec_i && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign done_o = (count == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a fixed-latency single-port memory between instruction fetch and data access.
// Optional IF starvation guard enabled by defining MEM_ARB_STARVE_GUARD_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MEM_LAT      = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_ready_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic              dm_ready_o,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              stall_o
);

    localparam int LAT_W = lat_cnt_w(MEM_LAT);

    if (MEM_LAT < 1 || MEM_LAT > 15 || STARVE_LIMIT < 1) begin : g_cfg_check
        $error("mem_arbiter: MEM_LAT must be 1..15 and STARVE_LIMIT at least 1");
    end

    arb_state_t        state, state_nxt;
    owner_t            owner;
    logic              lat_done, complete, arb_en;
    logic              force_if, grant_if, grant_dm, grant;
    logic [DATA_W-1:0] if_hold, dm_hold;

    // A new grant may be made while idle or in the cycle the current access returns.
    assign complete = (state != IDLE) && lat_done;
    assign arb_en   = (state == IDLE) || complete;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int STV_W = lat_cnt_w(STARVE_LIMIT);
    logic starve_done;

    // Counts down the DM grants still allowed while a fetch is waiting.
    arb_lat_timer #(.W(STV_W), .RST_VAL(STV_W'(STARVE_LIMIT))) u_starve (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (grant_if),
        .load_val_i (STV_W'(STARVE_LIMIT)),
        .dec_i      (grant_dm && if_req_i),
        .done_o     (starve_done)
    );
    assign force_if = starve_done && if_req_i;
`else
    assign force_if = 1'b0;
`endif

    assign grant_dm = arb_en && dm_req_i && !force_if;
    assign grant_if = arb_en && if_req_i && (!dm_req_i || force_if);
    assign grant    = grant_dm || grant_if;
    assign owner    = grant_dm ? OWN_DM : OWN_IF;

    arb_lat_timer #(.W(LAT_W)) u_lat (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (grant),
        .load_val_i (LAT_W'(MEM_LAT)),
        .dec_i      (1'b1),
        .done_o     (lat_done)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (grant_dm) begin
            state_nxt = BUSY_DM;
        end else if (grant_if) begin
            state_nxt = BUSY_IF;
        end else if (complete) begin
            state_nxt = IDLE;
        end
    end

    always_comb begin
        if_ready_o = complete && (state == BUSY_IF);
        dm_ready_o = complete && (state == BUSY_DM);
        if_rdata_o = if_ready_o ? mem_rdata_i : if_hold;
        dm_rdata_o = (dm_ready_o && !mem_we_o) ? mem_rdata_i : dm_hold;
    end

    // Memory fields hold the last issued access so mem_we_o still describes it at completion.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
        end else begin
            mem_req_o <= grant;
            if (grant) begin
                mem_addr_o  <= (owner == OWN_DM) ? dm_addr_i : if_addr_i;
                mem_we_o    <= (owner == OWN_DM) && dm_we_i;
                mem_wdata_o <= (owner == OWN_DM) ? dm_wdata_i : '0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            if_hold <= '0;
            dm_hold <= '0;
        end else begin
            if (if_ready_o) begin
                if_hold <= mem_rdata_i;
            end
            if (dm_ready_o && !mem_we_o) begin
                dm_hold <= mem_rdata_i;
            end
        end
    end

    assign stall_o = (if_req_i && !if_ready_o) || (dm_req_i && !dm_ready_o);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: timestamp-based transaction model plus directed scenarios (MEM_LAT=2 and MEM_LAT=1).
module tb_mem_arbiter;
    localparam int LAT   = 2;
    localparam int LIMIT = 4;
`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic if_req, dm_req, dm_we;
    logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
    logic if_ready, dm_ready, mem_req, mem_we, stall;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;

    logic b_if_req, b_dm_req, b_dm_we;
    logic [31:0] b_if_addr, b_dm_addr, b_dm_wdata, b_mem_rdata;
    logic b_if_ready, b_dm_ready, b_mem_req, b_mem_we, b_stall;
    logic [31:0] b_if_rdata, b_dm_rdata, b_mem_addr, b_mem_wdata;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .STARVE_LIMIT(LIMIT)) dut (
        .clk_i(clk), .rst_i(rst),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_ready_o(if_ready), .if_rdata_o(if_rdata),
        .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
        .dm_ready_o(dm_ready), .dm_rdata_o(dm_rdata),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata), .stall_o(stall)
    );

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_LIMIT(LIMIT)) dut_b (
        .clk_i(clk), .rst_i(rst),
        .if_req_i(b_if_req), .if_addr_i(b_if_addr), .if_ready_o(b_if_ready), .if_rdata_o(b_if_rdata),
        .dm_req_i(b_dm_req), .dm_we_i(b_dm_we), .dm_addr_i(b_dm_addr), .dm_wdata_i(b_dm_wdata),
        .dm_ready_o(b_dm_ready), .dm_rdata_o(b_dm_rdata),
        .mem_req_o(b_mem_req), .mem_we_o(b_mem_we), .mem_addr_o(b_mem_addr), .mem_wdata_o(b_mem_wdata),
        .mem_rdata_i(b_mem_rdata), .stall_o(b_stall)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Memory contents: preloaded words, otherwise a pattern derived from the address.
    logic [31:0] mem [logic [31:0]];
    function automatic logic [31:0] memval(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : {a[15:0], 16'h5A5A};
    endfunction

    // Memory responders: read data appears exactly LAT cycles after the issue cycle.
    logic p0_v, p1_v, bp_v;
    logic [31:0] p0_d, p1_d, bp_d;
    always @(posedge clk) begin
        p0_v <= mem_req && !mem_we;
        p0_d <= memval(mem_addr);
        p1_v <= p0_v;
        p1_d <= p0_d;
        bp_v <= b_mem_req && !b_mem_we;
        bp_d <= memval(b_mem_addr);
    end
    assign mem_rdata   = p1_v ? p1_d : 32'hBAD0BAD0;
    assign b_mem_rdata = bp_v ? bp_d : 32'hBAD0BAD0;

    // Model: at most one outstanding transaction, described by its issue cycle.
    typedef struct {
        bit          dm;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          issue;
    } txn_t;

    txn_t m_cur, m_last;
    bit m_act;
    int m_starve;
    logic [31:0] m_if_hold, m_dm_hold;
    bit give_if, give_dm;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_act = 1'b0;
            m_starve = 0;
            m_if_hold = '0;
            m_dm_hold = '0;
            m_last.dm = 1'b0; m_last.we = 1'b0; m_last.addr = '0;
            m_last.wdata = '0; m_last.rdata = '0; m_last.issue = -1;
        end else begin
            if (m_act && (cyc == m_cur.issue + LAT)) begin
                if (!m_cur.dm) m_if_hold = m_cur.rdata;
                else if (!m_cur.we) m_dm_hold = m_cur.rdata;
                m_act = 1'b0;
            end
            if (!m_act) begin
                give_if = if_req && (!dm_req || (GUARD && m_starve >= LIMIT));
                give_dm = dm_req && !give_if;
                if (give_dm) begin
                    m_cur.dm = 1'b1; m_cur.we = dm_we; m_cur.addr = dm_addr;
                    m_cur.wdata = dm_wdata; m_cur.rdata = memval(dm_addr);
                    if (dm_we) mem[dm_addr] = dm_wdata;
                    if (if_req && m_starve < LIMIT) m_starve++;
                end else if (give_if) begin
                    m_cur.dm = 1'b0; m_cur.we = 1'b0; m_cur.addr = if_addr;
                    m_cur.wdata = '0; m_cur.rdata = memval(if_addr);
                    m_starve = 0;
                end
                if (give_if || give_dm) begin
                    m_cur.issue = cyc + 1;
                    m_act = 1'b1;
                    m_last = m_cur;
                end
            end
        end
    end

    // Event log consumed by the directed checks.
    int ev_issue = -1, ev_if = -1, ev_dm = -1, n_if = 0, n_dm = 0;
    logic iss_we;
    logic [31:0] iss_addr, iss_wdata;
    bit b_on = 1'b0;
    int b_t0 = 0, b_n = 0;
    int bq_iss[$], bq_rdy[$];

    bit e_req, e_ifr, e_dmr, e_stall;
    logic [31:0] e_ifd, e_dmd;

    always @(negedge clk) begin
        e_req = m_act && (cyc == m_cur.issue);
        e_ifr = m_act && !m_cur.dm && (cyc == m_cur.issue + LAT);
        e_dmr = m_act && m_cur.dm && (cyc == m_cur.issue + LAT);
        e_ifd = e_ifr ? m_cur.rdata : m_if_hold;
        e_dmd = (e_dmr && !m_cur.we) ? m_cur.rdata : m_dm_hold;
        e_stall = (if_req && !e_ifr) || (dm_req && !e_dmr);
        chk("mem_req", 32'(mem_req), 32'(e_req));
        chk("mem_we", 32'(mem_we), 32'(m_last.we));
        chk("mem_addr", mem_addr, m_last.addr);
        chk("mem_wdata", mem_wdata, m_last.wdata);
        chk("if_ready", 32'(if_ready), 32'(e_ifr));
        chk("dm_ready", 32'(dm_ready), 32'(e_dmr));
        chk("if_rdata", if_rdata, e_ifd);
        chk("dm_rdata", dm_rdata, e_dmd);
        chk("stall", 32'(stall), 32'(e_stall));
        if (mem_req) begin
            ev_issue = cyc; iss_we = mem_we; iss_addr = mem_addr; iss_wdata = mem_wdata;
        end
        if (if_ready) begin ev_if = cyc; n_if++; end
        if (dm_ready) begin ev_dm = cyc; n_dm++; end

        chk("b_dm_ready", 32'(b_dm_ready), 32'd0);
        chk("b_mem_we", 32'(b_mem_we), 32'd0);
        chk("b_mem_wdata", b_mem_wdata, 32'd0);
        chk("b_dm_rdata", b_dm_rdata, 32'd0);
        chk("b_stall", 32'(b_stall), 32'(b_if_req && !b_if_ready));
        if (b_if_ready) chk("t6_rdata", b_if_rdata, 32'h00405A5A);
        if (b_on && b_mem_req) bq_iss.push_back(cyc - b_t0);
        if (b_on && b_if_ready) begin bq_rdy.push_back(cyc - b_t0); b_n++; end
    end

    // Requesters drop their request in the cycle the ready pulse is seen.
    bit auto_drop = 1'b1;
    task automatic step();
        @(negedge clk);
        #1;
        if (auto_drop && if_ready) if_req = 1'b0;
        if (auto_drop && dm_ready) dm_req = 1'b0;
        if (b_if_ready && b_n >= 4) b_if_req = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cmp(input int tgt, input int budget, input string nm);
        for (int k = 0; k < budget && (n_if + n_dm) < tgt; k++) step();
        chk(nm, n_if + n_dm, tgt);
    endtask

    int t0, base, nif0, ndm0;

    initial begin
        rst = 1'b1;
        if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0;
        b_if_req = 0; b_if_addr = 0; b_dm_req = 0; b_dm_we = 0; b_dm_addr = 0; b_dm_wdata = 0;
        mem[32'h10]  = 32'h8C020000;
        mem[32'h20]  = 32'h00221820;
        mem[32'h100] = 32'h00000005;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_mem_req", 32'(mem_req), 32'd0);
        chk("reset_stall", 32'(stall), 32'd0);
        rst = 1'b0;
        step();

        // Single fetch.
        t0 = cyc; base = n_if + n_dm;
        if_req = 1; if_addr = 32'h10;
        wait_cmp(base + 1, 20, "t1_done");
        chk("t1_issue_cyc", ev_issue - t0, 1);
        chk("t1_issue_addr", iss_addr, 32'h10);
        chk("t1_ready_cyc", ev_if - t0, 3);
        chk("t1_rdata", if_rdata, 32'h8C020000);
        step();

        // Simultaneous fetch and data read: data first.
        t0 = cyc; base = n_if + n_dm;
        if_req = 1; if_addr = 32'h20;
        dm_req = 1; dm_we = 0; dm_addr = 32'h100;
        wait_cmp(base + 2, 30, "t2_done");
        chk("t2_dm_ready_cyc", ev_dm - t0, 3);
        chk("t2_if_ready_cyc", ev_if - t0, 6);
        chk("t2_dm_rdata", dm_rdata, 32'h00000005);
        chk("t2_if_rdata", if_rdata, 32'h00221820);
        step();

        // Data write leaves dm_rdata untouched, then read it back.
        t0 = cyc; base = n_if + n_dm;
        dm_req = 1; dm_we = 1; dm_addr = 32'h104; dm_wdata = 32'hDEADBEEF;
        wait_cmp(base + 1, 20, "t3_done");
        chk("t3_issue_cyc", ev_issue - t0, 1);
        chk("t3_mem_we", 32'(iss_we), 32'd1);
        chk("t3_mem_wdata", iss_wdata, 32'hDEADBEEF);
        chk("t3_ready_cyc", ev_dm - t0, 3);
        chk("t3_dm_rdata_kept", dm_rdata, 32'h00000005);
        base = n_if + n_dm;
        dm_req = 1; dm_we = 0; dm_addr = 32'h104; dm_wdata = 0;
        wait_cmp(base + 1, 20, "t3_readback_done");
        chk("t3_readback", dm_rdata, 32'hDEADBEEF);
        step();

        // Asynchronous reset in the middle of a data read.
        t0 = cyc; ndm0 = n_dm;
        dm_req = 1; dm_we = 0; dm_addr = 32'h100;
        step(); step();
        #1 rst = 1'b1;
        #1;
        chk("t4_mem_req", 32'(mem_req), 32'd0);
        chk("t4_mem_addr", mem_addr, 32'd0);
        chk("t4_dm_rdata", dm_rdata, 32'd0);
        chk("t4_if_rdata", if_rdata, 32'd0);
        chk("t4_dm_ready", 32'(dm_ready), 32'd0);
        chk("t4_stall_req_driven", 32'(stall), 32'd1);
        dm_req = 0;
        step(); step();
        rst = 1'b0;
        repeat (5) step();
        chk("t4_no_ready", n_dm - ndm0, 0);
        t0 = cyc; base = n_if + n_dm;
        if_req = 1; if_addr = 32'h20;
        wait_cmp(base + 1, 20, "t4_after_reset_done");
        chk("t4_issue_cyc", ev_issue - t0, 1);
        chk("t4_ready_cyc", ev_if - t0, 3);
        step();

        // Both ports held continuously.
        auto_drop = 1'b0;
        t0 = cyc; base = n_if + n_dm; nif0 = n_if; ndm0 = n_dm;
        if_req = 1; if_addr = 32'h10;
        dm_req = 1; dm_we = 0; dm_addr = 32'h100;
`ifdef MEM_ARB_STARVE_GUARD_EN
        wait_cmp(base + 5, 40, "t5_five_done");
        chk("t5_if_count", n_if - nif0, 1);
        chk("t5_dm_count", n_dm - ndm0, 4);
        chk("t5_if_cycle", ev_if - t0, 15);
`else
        wait_cmp(base + 20, 100, "t5_twenty_done");
        chk("t5_if_count", n_if - nif0, 0);
        chk("t5_dm_count", n_dm - ndm0, 20);
        chk("t5_last_dm_cycle", ev_dm - t0, 60);
`endif
        if_req = 0; dm_req = 0;
        auto_drop = 1'b1;
        repeat (6) step();

        // MEM_LAT=1 instance: back-to-back fetches.
        b_t0 = cyc; b_on = 1'b1;
        b_if_req = 1; b_if_addr = 32'h40;
        for (int k = 0; k < 30 && b_n < 4; k++) step();
        repeat (3) step();
        chk("t6_issue_count", bq_iss.size(), 4);
        chk("t6_ready_count", bq_rdy.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk("t6_issue_cyc", (i < bq_iss.size()) ? bq_iss[i] : -1, 1 + 2 * i);
            chk("t6_ready_cyc", (i < bq_rdy.size()) ? bq_rdy[i] : -1, 2 + 2 * i);
        end

        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end

endmodule
